// File: rtl/cla_arb_pkg.sv
// Shared constants, ID-width helper and stage-1 layout for the shared-adder arbiter.
package cla_arb_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;

  // A single requester still needs a one-bit tag so the ID port never collapses to zero width.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

  // Stage-1 contents at the default configuration; the top rebuilds this shape at its own widths.
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_WIDTH-1:0] add1;
    logic [DEF_WIDTH-1:0] add2;
  } stage1_t;

endpackage

// File: rtl/cla_add_arbiter_if.sv
// Request and result streams between the client datapaths and the shared-adder arbiter.
interface cla_add_arbiter_if
  import cla_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ
) ();

  localparam int ID_W = id_width(NUM_REQ);

  // Handshake rule on both streams: a beat transfers on a rising clock edge where valid and
  // ready are both high; valid must not depend on ready, and data is stable while valid waits.
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ*WIDTH-1:0] i_req_add1;
  logic [NUM_REQ*WIDTH-1:0] i_req_add2;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic                     o_result_valid;
  logic                     i_result_ready;
  logic [WIDTH:0]           o_result;
  logic [ID_W-1:0]          o_result_id;
  logic                     o_busy;

  modport master (
    output i_req_valid, i_req_add1, i_req_add2, i_result_ready,
    input  o_req_ready, o_result_valid, o_result, o_result_id, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_add1, i_req_add2, i_result_ready,
    output o_req_ready, o_result_valid, o_result, o_result_id, o_busy
  );

endinterface

// File: rtl/carry_lookahead_adder.sv
// Carry-lookahead adder built from per-bit generate/propagate terms.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             acc;

  assign g = i_a & i_b;
  assign p = i_a ^ i_b;

  // Each carry is the generate/propagate recurrence unrolled; synthesis flattens it into lookahead terms.
  always_comb begin
    c    = '0;
    acc  = i_cin;
    c[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc      = g[i] | (p[i] & acc);
      c[i + 1] = acc;
    end
  end

  assign o_sum  = p ^ c[WIDTH-1:0];
  assign o_cout = c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot winner searched from the pointer upward with wrap.
module rr_arbiter
  import cla_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic                          i_en,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [id_width(NUM_REQ)-1:0]  o_grant_id,
  output logic                          o_any
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (i_en && !found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_grant_id   = idx;
        found        = 1'b1;
      end
    end
    o_any = found;
  end

  // The winner gets lowest priority next time, which bounds any wait to NUM_REQ grants.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Shares one carry-lookahead adder among NUM_REQ requesters through a two-stage pipeline.
module cla_add_arbiter
  import cla_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cla_add_arbiter_if.slave  bus
);

  localparam int ID_W = id_width(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] add1;
    logic [WIDTH-1:0] add2;
  } s1_t;

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH:0]   s2_sum;
  logic [ID_W-1:0]  s2_id;
  logic             s1_adv;
  logic             s2_adv;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign s2_adv = !s2_valid || bus.i_result_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Grants are suppressed during reset so nothing appears accepted while the pipeline is cleared.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (bus.i_req_valid),
    .i_en       (s1_adv && !i_rst),
    .o_grant    (grant),
    .o_grant_id (grant_id),
    .o_any      (grant_any)
  );

  always_comb begin
    s1_d    = '0;
    s1_d.id = grant_id;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        s1_d.add1 = bus.i_req_add1[k*WIDTH +: WIDTH];
        s1_d.add2 = bus.i_req_add2[k*WIDTH +: WIDTH];
      end
    end
  end

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_add (
    .i_a    (s1_q.add1),
    .i_b    (s1_q.add2),
    .i_cin  (1'b0),
    .o_sum  (sum),
    .o_cout (cout)
  );

  // Both stages may move on the same edge, so a drain, a shift and a new accept never bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_id    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= grant_any;
        if (grant_any) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_sum   <= {cout, sum};
        s2_id    <= s1_q.id;
      end
    end
  end

  assign bus.o_req_ready    = grant;
  assign bus.o_result_valid = s2_valid;
  assign bus.o_result       = s2_sum;
  assign bus.o_result_id    = s2_id;
  assign bus.o_busy         = s1_valid || s2_valid;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter (WIDTH=8, NUM_REQ=4) with an expected-result queue.
module tb_cla_add_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_add_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

  cla_add_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0]  a [4];
  logic [7:0]  b [4];
  logic [8:0]  s [4];
  logic [10:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign bus.i_req_add1 = {a[3], a[2], a[1], a[0]};
  assign bus.i_req_add2 = {b[3], b[2], b[1], b[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = '0;
    for (int k = 0; k < 4; k++) if (g[k]) enc = 2'(k);
  endfunction

  // One clock: check the grant, score any result leaving, record any accept, then step past the edge.
  task automatic cycle(input logic [3:0] g, input logic [8:0] sum);
    logic [10:0] e;
    #1;
    check("grant", 32'(bus.o_req_ready), 32'(g));
    if (bus.o_result_valid && bus.i_result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.o_result_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(bus.o_result), 32'(e[8:0]));
        check("result_id", 32'(bus.o_result_id), 32'(e[10:9]));
      end
    end
    if (g != 4'b0000) exp_q.push_back({enc(g), sum});
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst                = 1'b1;
    bus.i_req_valid    = 4'b0001;
    bus.i_result_ready = 1'b1;
    a = '{8'hFF, 8'h00, 8'h00, 8'h00};
    b = '{8'h01, 8'h00, 8'h00, 8'h00};

    // Reset state, including no grant even though req0 is valid.
    @(posedge clk);
    #2;
    check("rst_ready", 32'(bus.o_req_ready), 32'(0));
    check("rst_valid", 32'(bus.o_result_valid), 32'(0));
    check("rst_result", 32'(bus.o_result), 32'(0));
    check("rst_id", 32'(bus.o_result_id), 32'(0));
    check("rst_busy", 32'(bus.o_busy), 32'(0));
    rst = 1'b0;

    // Single request: 0xFF + 0x01 from req0.
    cycle(4'b0001, 9'h100);
    bus.i_req_valid = 4'b0000;
    check("single_busy_n1", 32'(bus.o_busy), 32'(1));
    check("single_valid_n1", 32'(bus.o_result_valid), 32'(0));
    cycle(4'b0000, 9'h000);
    check("single_valid_n2", 32'(bus.o_result_valid), 32'(1));
    check("single_busy_n2", 32'(bus.o_busy), 32'(1));
    cycle(4'b0000, 9'h000);
    check("single_valid_n3", 32'(bus.o_result_valid), 32'(0));
    check("single_busy_n3", 32'(bus.o_busy), 32'(0));

    // Streaming from a fresh pointer: grants 0,1,2,3,0,...
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_q.delete();
    a = '{8'h01, 8'h33, 8'h70, 8'hF0};
    b = '{8'h02, 8'h44, 8'h90, 8'h20};
    s = '{9'h003, 9'h077, 9'h100, 9'h110};
    bus.i_req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) check("stream_valid", 32'(bus.o_result_valid), 32'(1));
      cycle(4'(1 << (i % 4)), s[i % 4]);
    end
    bus.i_req_valid = 4'b0000;
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);
    check("stream_idle", 32'(bus.o_busy), 32'(0));

    // Backpressure: two accepts fill the pipe, then grants stop and the result holds.
    bus.i_req_valid    = 4'b1111;
    bus.i_result_ready = 1'b0;
    cycle(4'b0001, s[0]);
    cycle(4'b0010, s[1]);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(bus.o_result_valid), 32'(1));
      check("hold_result", 32'(bus.o_result), 32'(9'h003));
      check("hold_id", 32'(bus.o_result_id), 32'(0));
      cycle(4'b0000, 9'h000);
    end
    bus.i_result_ready = 1'b1;
    cycle(4'b0100, s[2]);
    cycle(4'b1000, s[3]);
    bus.i_req_valid = 4'b0000;
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);
    check("bp_idle", 32'(bus.o_busy), 32'(0));
    check("bp_queue", 32'(exp_q.size()), 32'(0));

    // Round robin: after req2, req3 beats req1.
    bus.i_req_valid = 4'b0100;
    cycle(4'b0100, s[2]);
    bus.i_req_valid = 4'b1010;
    cycle(4'b1000, s[3]);
    bus.i_req_valid = 4'b0010;
    cycle(4'b0010, s[1]);
    bus.i_req_valid = 4'b0000;
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);

    // Boundary operands on req0.
    bus.i_req_valid = 4'b0001;
    a[0] = 8'hFF; b[0] = 8'hFF;
    cycle(4'b0001, 9'h1FE);
    a[0] = 8'h00; b[0] = 8'h00;
    cycle(4'b0001, 9'h000);
    a[0] = 8'h80; b[0] = 8'h80;
    cycle(4'b0001, 9'h100);
    bus.i_req_valid = 4'b0000;
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);
    check("bnd_queue", 32'(exp_q.size()), 32'(0));

    // Async reset with both stages full, then the pointer restarts at 0.
    bus.i_req_valid    = 4'b1111;
    bus.i_result_ready = 1'b0;
    cycle(4'b0010, 9'h077);
    cycle(4'b0100, 9'h100);
    check("full_valid", 32'(bus.o_result_valid), 32'(1));
    check("full_busy", 32'(bus.o_busy), 32'(1));
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.o_result_valid), 32'(0));
    check("arst_busy", 32'(bus.o_busy), 32'(0));
    check("arst_result", 32'(bus.o_result), 32'(0));
    check("arst_ready", 32'(bus.o_req_ready), 32'(0));
    rst = 1'b0;
    exp_q.delete();
    bus.i_req_valid    = 4'b1001;
    bus.i_result_ready = 1'b1;
    cycle(4'b0001, 9'h100);
    bus.i_req_valid = 4'b1000;
    cycle(4'b1000, 9'h110);
    bus.i_req_valid = 4'b0000;
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);
    cycle(4'b0000, 9'h000);
    check("end_busy", 32'(bus.o_busy), 32'(0));
    check("end_queue", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
